// File: rtl/ahb_defines.sv
// rtl/ahb_defines.sv - shared AHB encodings, burst length helper and arbiter state type
package ahb_defines;

    localparam logic [1:0] AHB_TRANS_IDLE   = 2'b00;
    localparam logic [1:0] AHB_TRANS_BUSY   = 2'b01;
    localparam logic [1:0] AHB_TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] AHB_TRANS_SEQ    = 2'b11;

    localparam logic [2:0] AHB_BURST_SINGLE = 3'b000;
    localparam logic [2:0] AHB_BURST_INCR   = 3'b001;
    localparam logic [2:0] AHB_BURST_WRAP4  = 3'b010;
    localparam logic [2:0] AHB_BURST_INCR4  = 3'b011;
    localparam logic [2:0] AHB_BURST_WRAP8  = 3'b100;
    localparam logic [2:0] AHB_BURST_INCR8  = 3'b101;
    localparam logic [2:0] AHB_BURST_WRAP16 = 3'b110;
    localparam logic [2:0] AHB_BURST_INCR16 = 3'b111;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWN   = 2'd1,
        ARB_BURST = 2'd2,
        ARB_LOCK  = 2'd3
    } arb_state_e;

    // Beats remaining after the NONSEQ of a fixed-length burst; 0 for SINGLE/INCR.
    function automatic logic [3:0] burst_beats_m1(input logic [2:0] burst);
        case (burst)
            AHB_BURST_WRAP4,  AHB_BURST_INCR4:  burst_beats_m1 = 4'd3;
            AHB_BURST_WRAP8,  AHB_BURST_INCR8:  burst_beats_m1 = 4'd7;
            AHB_BURST_WRAP16, AHB_BURST_INCR16: burst_beats_m1 = 4'd15;
            default:                            burst_beats_m1 = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// rtl/ahb_rr_picker.sv - combinational round-robin selector starting after ptr
module ahb_rr_picker #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any_req
);

    logic [N-1:0] rotated;

    // rotated[i] is the request of master (ptr + 1 + i) mod N
    assign rotated = N'({req, req} >> (int'(ptr) + 1));

    always_comb begin
        idx     = '0;
        any_req = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                any_req = 1'b1;
                idx     = W'((int'(ptr) + 1 + i) % N);
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - round-robin AHB arbiter honouring fixed bursts, locks and ERROR
module ahb_arbiter
    import ahb_defines::*;
#(
    parameter int MASTER_NUM     = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MASTER_W       = 2
) (
    input  logic                  ahb_clk_in,
    input  logic                  ahb_rstn_in,
    input  logic [MASTER_NUM-1:0] ahb_busreq_in,
    input  logic [MASTER_NUM-1:0] ahb_lock_in,
    input  logic [1:0]            ahb_trans_in,
    input  logic [2:0]            ahb_burst_in,
    input  logic                  ahb_ready_in,
    input  logic                  ahb_resp_in,
    output logic [MASTER_NUM-1:0] ahb_grant_out,
    output logic [MASTER_W-1:0]   ahb_master_out,
    output logic [MASTER_W-1:0]   ahb_master_data_out,
    output logic                  ahb_mastlock_out
);

    localparam logic [MASTER_W-1:0]   DEF_IDX   = MASTER_W'(DEFAULT_MASTER);
    localparam logic [MASTER_NUM-1:0] DEF_GRANT = MASTER_NUM'(1) << DEFAULT_MASTER;

    arb_state_e          state, state_nx;
    logic [3:0]          cnt, cnt_nx;
    logic [MASTER_W-1:0] ptr, rr_idx, pick;
    logic                any_req, rearb_ok;
    logic                is_nonseq, is_seq, lock_hold, locked_now;
    logic [3:0]          beats_m1;

    ahb_rr_picker #(.N(MASTER_NUM), .W(MASTER_W)) u_picker (
        .req     (ahb_busreq_in),
        .ptr     (ptr),
        .idx     (rr_idx),
        .any_req (any_req)
    );

    assign pick       = any_req ? rr_idx : DEF_IDX;
    assign is_nonseq  = ahb_ready_in && (ahb_trans_in == AHB_TRANS_NONSEQ);
    assign is_seq     = ahb_ready_in && (ahb_trans_in == AHB_TRANS_SEQ);
    assign lock_hold  = ahb_lock_in[ahb_master_out];
    assign locked_now = (state == ARB_LOCK) && lock_hold;
    assign beats_m1   = burst_beats_m1(ahb_burst_in);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rearb_ok = 1'b0;
        case (state)
            ARB_IDLE, ARB_OWN: begin
                rearb_ok = 1'b1;
                if (ahb_ready_in)
                    state_nx = (ahb_trans_in == AHB_TRANS_IDLE) ? ARB_IDLE : ARB_OWN;
            end
            ARB_BURST: begin
                if (is_seq) begin
                    cnt_nx = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        rearb_ok = 1'b1;
                        state_nx = ARB_OWN;
                    end
                end
            end
            ARB_LOCK: begin
                if (!lock_hold) begin
                    rearb_ok = 1'b1;
                    if (ahb_ready_in)
                        state_nx = (ahb_trans_in == AHB_TRANS_IDLE) ? ARB_IDLE : ARB_OWN;
                end
            end
            default: state_nx = ARB_IDLE;
        endcase

        // A NONSEQ opens a new sequence (also early-terminates a burst) unless a lock is active
        if (is_nonseq && !locked_now) begin
            if (lock_hold) begin
                state_nx = ARB_LOCK;
                rearb_ok = 1'b0;
            end else if (beats_m1 != 4'd0) begin
                state_nx = ARB_BURST;
                cnt_nx   = beats_m1;
                rearb_ok = 1'b0;
            end else begin
                state_nx = ARB_OWN;
                rearb_ok = 1'b1;
            end
        end

        if (ahb_ready_in && ahb_resp_in) begin
            cnt_nx = 4'd0;
            if (locked_now) begin
                state_nx = ARB_LOCK;
                rearb_ok = 1'b0;
            end else begin
                state_nx = ARB_IDLE;
                rearb_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
        if (!ahb_rstn_in) begin
            state               <= ARB_IDLE;
            cnt                 <= 4'd0;
            ptr                 <= DEF_IDX;
            ahb_grant_out       <= DEF_GRANT;
            ahb_master_out      <= DEF_IDX;
            ahb_master_data_out <= DEF_IDX;
            ahb_mastlock_out    <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (ahb_ready_in) begin
                ahb_master_data_out <= ahb_master_out;
                if (rearb_ok) begin
                    ahb_grant_out    <= MASTER_NUM'(1) << pick;
                    ahb_master_out   <= pick;
                    ptr              <= pick;
                    ahb_mastlock_out <= ahb_lock_in[pick];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb/tb_ahb_arbiter.sv - directed self-checking bench for ahb_arbiter
module tb_ahb_arbiter;
    import ahb_defines::*;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] busreq = '0, busreq2 = '0, lock = '0;
    logic [1:0]   trans = AHB_TRANS_IDLE;
    logic [2:0]   burst = AHB_BURST_SINGLE;
    logic         ready = 1'b1, resp = 1'b0;
    logic [N-1:0] grant, grant2;
    logic [W-1:0] master, mdata, master2, mdata2;
    logic         mastlock, mastlock2;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    ahb_arbiter #(.MASTER_NUM(N), .DEFAULT_MASTER(0), .MASTER_W(W)) dut (
        .ahb_clk_in(clk), .ahb_rstn_in(rst_n), .ahb_busreq_in(busreq), .ahb_lock_in(lock),
        .ahb_trans_in(trans), .ahb_burst_in(burst), .ahb_ready_in(ready), .ahb_resp_in(resp),
        .ahb_grant_out(grant), .ahb_master_out(master), .ahb_master_data_out(mdata),
        .ahb_mastlock_out(mastlock)
    );

    ahb_arbiter #(.MASTER_NUM(N), .DEFAULT_MASTER(2), .MASTER_W(W)) dut2 (
        .ahb_clk_in(clk), .ahb_rstn_in(rst_n), .ahb_busreq_in(busreq2), .ahb_lock_in(lock),
        .ahb_trans_in(trans), .ahb_burst_in(burst), .ahb_ready_in(ready), .ahb_resp_in(resp),
        .ahb_grant_out(grant2), .ahb_master_out(master2), .ahb_master_data_out(mdata2),
        .ahb_mastlock_out(mastlock2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; busreq = '0; busreq2 = '0; lock = '0;
        trans = AHB_TRANS_IDLE; burst = AHB_BURST_SINGLE; ready = 1'b1; resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL reset_grant: got %b expected 0001", grant); end
        checks++; if (master !== 2'd0) begin errors++; $display("FAIL reset_master: got %0d expected 0", master); end
        checks++; if (mdata !== 2'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", mdata); end
        checks++; if (mastlock !== 1'b0) begin errors++; $display("FAIL reset_mastlock: got %b expected 0", mastlock); end
        checks++; if (grant2 !== 4'b0100) begin errors++; $display("FAIL reset_grant_def2: got %b expected 0100", grant2); end
        checks++; if (master2 !== 2'd2 || mdata2 !== 2'd2) begin
            errors++; $display("FAIL reset_idx_def2: got %0d/%0d expected 2/2", master2, mdata2);
        end
        step();
        checks++; if (grant !== 4'b0001 || grant2 !== 4'b0100) begin
            errors++; $display("FAIL idle_default: got %b/%b expected 0001/0100", grant, grant2);
        end
    endtask

    task automatic test_round_robin();
        logic [W-1:0] exp_m, exp_d;
        apply_reset();
        busreq = 4'b0110; trans = AHB_TRANS_NONSEQ; burst = AHB_BURST_SINGLE;
        exp_m = 2'd0;
        for (int i = 0; i < 4; i++) begin
            exp_d = exp_m;
            exp_m = (i % 2 == 0) ? 2'd1 : 2'd2;
            step();
            checks++; if (grant !== (4'b0001 << exp_m)) begin
                errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, grant, 4'b0001 << exp_m);
            end
            checks++; if (master !== exp_m) begin errors++; $display("FAIL rr_master[%0d]: got %0d expected %0d", i, master, exp_m); end
            checks++; if (mdata !== exp_d) begin errors++; $display("FAIL rr_data[%0d]: got %0d expected %0d", i, mdata, exp_d); end
        end
    endtask

    task automatic test_burst_hold();
        logic [1:0] tr [7];
        logic       rd [7];
        logic [3:0] eg [7];
        tr = '{AHB_TRANS_NONSEQ, AHB_TRANS_SEQ, AHB_TRANS_BUSY, AHB_TRANS_SEQ,
               AHB_TRANS_SEQ, AHB_TRANS_SEQ, AHB_TRANS_SEQ};
        rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        eg = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
        apply_reset();
        busreq = 4'b0100;
        step();
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL burst_setup: got %b expected 0100", grant); end
        busreq = 4'b1100; burst = AHB_BURST_INCR4;
        for (int i = 0; i < 7; i++) begin
            trans = tr[i]; ready = rd[i];
            step();
            checks++; if (grant !== eg[i]) begin errors++; $display("FAIL burst_grant[%0d]: got %b expected %b", i, grant, eg[i]); end
        end
        ready = 1'b1;
    endtask

    task automatic test_error();
        apply_reset();
        busreq = 4'b0010;
        step();
        busreq = 4'b0011; trans = AHB_TRANS_NONSEQ; burst = AHB_BURST_INCR8;
        step();
        trans = AHB_TRANS_SEQ;
        step();
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL err_pre: got %b expected 0010", grant); end
        resp = 1'b1;
        step();
        resp = 1'b0; trans = AHB_TRANS_IDLE;
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL err_grant: got %b expected 0001", grant); end
        checks++; if (master !== 2'd0) begin errors++; $display("FAIL err_master: got %0d expected 0", master); end
        checks++; if (mdata !== 2'd1) begin errors++; $display("FAIL err_data: got %0d expected 1", mdata); end
    endtask

    task automatic test_lock();
        apply_reset();
        busreq = 4'b1000; lock = 4'b1000;
        step();
        checks++; if (grant !== 4'b1000 || mastlock !== 1'b1) begin
            errors++; $display("FAIL lock_acquire: got %b/%b expected 1000/1", grant, mastlock);
        end
        busreq = 4'b1001; trans = AHB_TRANS_NONSEQ; burst = AHB_BURST_SINGLE;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (grant !== 4'b1000 || mastlock !== 1'b1) begin
                errors++; $display("FAIL lock_hold[%0d]: got %b/%b expected 1000/1", i, grant, mastlock);
            end
        end
        lock = 4'b0000; trans = AHB_TRANS_IDLE;
        step();
        checks++; if (grant !== 4'b0001 || mastlock !== 1'b0) begin
            errors++; $display("FAIL lock_release: got %b/%b expected 0001/0", grant, mastlock);
        end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        busreq = 4'b0010; lock = 4'b0010;
        step();
        lock = 4'b0000; trans = AHB_TRANS_NONSEQ; burst = AHB_BURST_INCR8;
        step();
        trans = AHB_TRANS_SEQ;
        step();
        checks++; if (grant !== 4'b0010 || mastlock !== 1'b1 || mdata !== 2'd1) begin
            errors++; $display("FAIL midrst_pre: got %b/%b/%0d expected 0010/1/1", grant, mastlock, mdata);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL midrst_grant: got %b expected 0001", grant); end
        checks++; if (master !== 2'd0 || mdata !== 2'd0) begin
            errors++; $display("FAIL midrst_idx: got %0d/%0d expected 0/0", master, mdata);
        end
        checks++; if (mastlock !== 1'b0) begin errors++; $display("FAIL midrst_mastlock: got %b expected 0", mastlock); end
    endtask

    task automatic test_default_master();
        apply_reset();
        busreq = 4'b0100;
        step();
        busreq = 4'b0000; trans = AHB_TRANS_NONSEQ; burst = AHB_BURST_SINGLE;
        step();
        checks++; if (grant !== 4'b0001 || master !== 2'd0) begin
            errors++; $display("FAIL default_grant: got %b/%0d expected 0001/0", grant, master);
        end
        checks++; if (mdata !== 2'd2) begin errors++; $display("FAIL default_data: got %0d expected 2", mdata); end
        busreq2 = 4'b0010;
        step();
        checks++; if (grant2 !== 4'b0010) begin errors++; $display("FAIL def2_pick: got %b expected 0010", grant2); end
        busreq2 = 4'b0000;
        step();
        checks++; if (grant2 !== 4'b0100 || master2 !== 2'd2) begin
            errors++; $display("FAIL def2_return: got %b/%0d expected 0100/2", grant2, master2);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst_hold();
        test_error();
        test_lock();
        test_reset_mid_burst();
        test_default_master();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 time units");
        $fatal(1);
    end

endmodule
